piece_exec_stage: RTL

Multi-cycle execute stage for the tetris CPU pipeline and the parametrised successor of the step-2 ALU stage. It takes one decoded instruction (command, direction) plus the active piece's cell coordinates. It computes the candidate position (move or rotate) and checks every candidate cell against field bounds and a latched occupancy bitmap. It returns the accepted coordinates together with `is_move` and `is_touch`. It sits between decode and write-back, with valid/ready handshakes on both sides.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cell_probe.sv | 29 ++
 rtl/piece_exec_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - command/direction codes and execute-stage state encoding
package cpu_pkg;

    localparam int unsigned CMD_NOP   = 0;
    localparam int unsigned CMD_MOVE  = 1;
    localparam int unsigned CMD_ROT   = 2;

    localparam int unsigned DIR_LEFT  = 0;
    localparam int unsigned DIR_RIGHT = 1;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned ROT_CW    = 0;
    localparam int unsigned ROT_CCW   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_TOUCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cell_probe.sv
// rtl/cell_probe.sv - combinational bounds and occupancy test for one cell
module cell_probe #(
    parameter int MEM_WIDTH  = 4,
    parameter int MEM_HEIGHT = 4,
    parameter int WIDTH      = 8
) (
    input  logic [WIDTH-1:0]                x,
    input  logic [WIDTH-1:0]                y,
    input  logic [MEM_WIDTH*MEM_HEIGHT-1:0] field,
    output logic                            blocked
);

    logic hit;

    // Wrapped negative coordinates land far above the field and fail the bounds test.
    always_comb begin
        hit = 1'b0;
        for (int r = 0; r < MEM_HEIGHT; r++) begin
            for (int c = 0; c < MEM_WIDTH; c++) begin
                if (y == WIDTH'(r) && x == WIDTH'(c) && field[r*MEM_WIDTH + c]) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign blocked = hit || (x >= WIDTH'(MEM_WIDTH)) || (y >= WIDTH'(MEM_HEIGHT));

endmodule

// File: rtl/piece_exec_stage.sv
// rtl/piece_exec_stage.sv - multi-cycle move/rotate execute stage with collision and touch probing
module piece_exec_stage
    import cpu_pkg::*;
#(
    parameter int MEM_WIDTH  = 4,
    parameter int MEM_HEIGHT = 4,
    parameter int WIDTH      = 8,
    parameter int CELLS      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2*WIDTH-1:0]              instr,
    input  logic [WIDTH*CELLS-1:0]          coord_x,
    input  logic [WIDTH*CELLS-1:0]          coord_y,
    input  logic [MEM_WIDTH*MEM_HEIGHT-1:0] field,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH*CELLS-1:0]          new_coord_x,
    output logic [WIDTH*CELLS-1:0]          new_coord_y,
    output logic                            is_move,
    output logic                            is_touch,
    output logic                            err
);

    localparam int IW = $clog2(CELLS) + 1;

    state_t                          state;
    logic [IW-1:0]                   idx;
    logic                            blk;
    logic                            tch;
    logic [WIDTH*CELLS-1:0]          orig_x, orig_y, cand_xr, cand_yr;
    logic [MEM_WIDTH*MEM_HEIGHT-1:0] field_r;
    logic                            op_active, op_err;

    logic [WIDTH-1:0]                cmd, dir, px, py;
    logic                            move_ok, rot_ok;
    logic [WIDTH*CELLS-1:0]          cand_x, cand_y;
    logic [WIDTH-1:0]                probe_x, probe_y;
    logic                            probe_blk, blk_next, last;

    assign cmd = instr[2*WIDTH-1:WIDTH];
    assign dir = instr[WIDTH-1:0];
    assign px  = coord_x[WIDTH-1:0];
    assign py  = coord_y[WIDTH-1:0];

    assign move_ok = (cmd == WIDTH'(CMD_MOVE)) &&
                     (dir == WIDTH'(DIR_LEFT) || dir == WIDTH'(DIR_RIGHT) || dir == WIDTH'(DIR_DOWN));
    assign rot_ok  = (cmd == WIDTH'(CMD_ROT)) &&
                     (dir == WIDTH'(ROT_CW) || dir == WIDTH'(ROT_CCW));

    for (genvar i = 0; i < CELLS; i++) begin : g_cand
        logic [WIDTH-1:0] ox, oy, dx, dy, nx, ny;
        assign ox = coord_x[i*WIDTH +: WIDTH];
        assign oy = coord_y[i*WIDTH +: WIDTH];
        assign dx = ox - px;
        assign dy = oy - py;
        // Rotation about cell 0 in modulo-2^WIDTH arithmetic; wrap-around is caught by the bounds probe.
        always_comb begin
            nx = ox;
            ny = oy;
            if (move_ok) begin
                if (dir == WIDTH'(DIR_LEFT))       nx = ox - WIDTH'(1);
                else if (dir == WIDTH'(DIR_RIGHT)) nx = ox + WIDTH'(1);
                else                               ny = oy + WIDTH'(1);
            end else if (rot_ok) begin
                if (dir == WIDTH'(ROT_CW)) begin
                    nx = px - dy;
                    ny = py + dx;
                end else begin
                    nx = px + dy;
                    ny = py - dx;
                end
            end
        end
        assign cand_x[i*WIDTH +: WIDTH] = nx;
        assign cand_y[i*WIDTH +: WIDTH] = ny;
    end

    // One shared probe: candidates during CHECK, committed cells shifted down one row during TOUCH.
    always_comb begin
        probe_x = '0;
        probe_y = '0;
        for (int k = 0; k < CELLS; k++) begin
            if (idx == IW'(k)) begin
                if (state == ST_TOUCH) begin
                    probe_x = new_coord_x[k*WIDTH +: WIDTH];
                    probe_y = new_coord_y[k*WIDTH +: WIDTH] + WIDTH'(1);
                end else begin
                    probe_x = cand_xr[k*WIDTH +: WIDTH];
                    probe_y = cand_yr[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    cell_probe #(
        .MEM_WIDTH  (MEM_WIDTH),
        .MEM_HEIGHT (MEM_HEIGHT),
        .WIDTH      (WIDTH)
    ) u_probe (
        .x       (probe_x),
        .y       (probe_y),
        .field   (field_r),
        .blocked (probe_blk)
    );

    assign blk_next  = blk | probe_blk;
    assign last      = (idx == IW'(CELLS - 1));
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            blk         <= 1'b0;
            tch         <= 1'b0;
            orig_x      <= '0;
            orig_y      <= '0;
            cand_xr     <= '0;
            cand_yr     <= '0;
            field_r     <= '0;
            op_active   <= 1'b0;
            op_err      <= 1'b0;
            new_coord_x <= '0;
            new_coord_y <= '0;
            is_move     <= 1'b0;
            is_touch    <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        orig_x    <= coord_x;
                        orig_y    <= coord_y;
                        cand_xr   <= cand_x;
                        cand_yr   <= cand_y;
                        field_r   <= field;
                        op_active <= move_ok || rot_ok;
                        op_err    <= !(move_ok || rot_ok || cmd == WIDTH'(CMD_NOP));
                        idx       <= '0;
                        blk       <= 1'b0;
                        tch       <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    blk <= blk_next;
                    if (last) begin
                        new_coord_x <= blk_next ? orig_x : cand_xr;
                        new_coord_y <= blk_next ? orig_y : cand_yr;
                        is_move     <= !blk_next && op_active;
                        err         <= op_err;
                        idx         <= '0;
                        state       <= ST_TOUCH;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_TOUCH: begin
                    tch <= tch | probe_blk;
                    if (last) begin
                        is_touch <= tch | probe_blk;
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    if (out_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
